// File: rtl/trng_fifo_ctrl.sv
// trng_fifo_ctrl: packs the serial TRNG bit stream into 32-bit FIFO words and serves single-word host reads
module trng_fifo_ctrl #(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  output logic                  fifo_wr_en,
  output logic [31:0]           fifo_wr_data,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [31:0]           fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  host_rd_req,
  output logic                  host_rd_valid,
  output logic [31:0]           host_rd_data,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t      state;
  logic [31:0] sreg;
  logic [4:0]  cnt;
  logic [31:0] next_word;
  assign next_word = {sreg[30:0], bit_in};
  // the completed word is pushed straight from next_word, so the shifter never stalls at word boundaries
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg         <= '0;
      cnt          <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      drop_cnt     <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      if (!enable) begin
        sreg <= '0;
        cnt  <= '0;
      end else if (bit_valid) begin
        sreg <= next_word;
        cnt  <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          if (!fifo_full) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= next_word;
          end else if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      fifo_rd_en    <= 1'b0;
      host_rd_valid <= 1'b0;
      host_rd_data  <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (host_rd_req && !fifo_empty) begin
          state      <= ISSUE;
          fifo_rd_en <= 1'b1;
          busy       <= 1'b1;
        end
        ISSUE: begin
          state      <= WAIT;
          fifo_rd_en <= 1'b0;
        end
        WAIT: begin
          state         <= RESP;
          host_rd_data  <= fifo_rd_data;
          host_rd_valid <= 1'b1;
        end
        RESP: begin
          state         <= IDLE;
          host_rd_valid <= 1'b0;
          busy          <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trng_fifo_ctrl.sv
// tb_trng_fifo_ctrl: randomized scoreboard bench for trng_fifo_ctrl with a queue-based FIFO stand-in
module tb_trng_fifo_ctrl;
  localparam int DW   = 3;
  localparam int DMAX = (1 << DW) - 1;
  logic clk = 0, rst_n = 0, enable = 0, bit_valid = 0, bit_in = 0, fifo_full = 0, host_rd_req = 0;
  logic fifo_wr_en, fifo_rd_en, host_rd_valid, busy;
  logic [31:0] fifo_wr_data, host_rd_data;
  logic [31:0] fifo_rd_data = 0;
  logic fifo_empty = 1;
  logic [DW-1:0] drop_cnt;
  logic push_valid = 0;
  logic [31:0] push_w = 0;
  int cyc = 0, nvec = 0, nerr = 0, drops = 0, rd_cnt = 0, rd_cyc = 0;
  typedef struct {logic [31:0] d; int c;} wexp_t;
  wexp_t       wq[$];
  logic [31:0] rq[$];
  logic [31:0] fq[$];
  int          vq[$];
  bit          bits[$];

  trng_fifo_ctrl #(.DROP_CNT_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bit_valid(bit_valid), .bit_in(bit_in),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .host_rd_req(host_rd_req), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO stand-in with one-cycle registered read data
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_rd_data <= fq[0];
      rq.push_back(fq[0]);
      fq.delete(0);
    end
    if (push_valid) fq.push_back(push_w);
    fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    wexp_t e;
    forever begin
      @(negedge clk);
      if (fifo_wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", fifo_wr_en, 0);
        else begin
          e = wq.pop_front();
          chk("wr_data", fifo_wr_data, e.d);
          chk("wr_cycle", cyc, e.c);
        end
      end
      if (fifo_rd_en) begin
        chk("rd_en_while_empty", fifo_empty, 0);
        rd_cnt++;
        rd_cyc = cyc;
      end
      if (host_rd_valid) begin
        if (rq.size() == 0) chk("valid_unexpected", host_rd_valid, 0);
        else chk("rd_data", host_rd_data, rq.pop_front());
        vq.push_back(cyc);
      end
    end
  endtask

  // one clock of stimulus; the reference model reassembles words from the accepted bit list
  task automatic step(input logic en, input logic f, input logic v, input logic b);
    logic [31:0] w;
    @(posedge clk); #1;
    push_valid = 0;
    enable = en; fifo_full = f; bit_valid = v; bit_in = b;
    if (!en) bits.delete();
    else if (v) begin
      bits.push_back(b);
      if (bits.size() == 32) begin
        if (f) drops = (drops == DMAX) ? DMAX : drops + 1;
        else begin
          w = 0;
          foreach (bits[i]) w[31-i] = bits[i];
          wq.push_back('{w, cyc + 1});
        end
        bits.delete();
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic f, input bit gaps);
    for (int i = 31; i >= 0; i--) begin
      while (gaps && $urandom_range(0, 2) == 0) step(1, f, 0, $urandom % 2 == 1);
      step(1, f, 1, w[i]);
    end
  endtask

  task automatic drain();
    repeat (3) step(0, 0, 0, 0);
    chk("wr_drain", wq.size(), 0);
  endtask

  task automatic preload(input logic [31:0] w);
    step(0, 0, 0, 0);
    push_valid = 1; push_w = w;
    step(0, 0, 0, 0);
  endtask

  task automatic do_read(output int c0, output int vc, output logic [7:0] bz);
    bz = '0; vc = -1;
    step(0, 0, 0, 0);
    host_rd_req = 1; c0 = cyc;
    for (int k = 0; k < 40 && vc < 0; k++) begin
      @(negedge clk);
      if (k < 8) bz[k] = busy;
      if (host_rd_valid) vc = cyc;
    end
    chk("rd_done", vc >= 0, 1);
    step(0, 0, 0, 0);
    host_rd_req = 0;
    @(negedge clk);
    if (vc >= 0 && cyc - c0 < 8) bz[cyc-c0] = busy;
  endtask

  initial begin
    int c0, vc, n0, pc, nv;
    logic [7:0] bz;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", host_rd_valid, 0);
    chk("rst_rd_data", host_rd_data, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    step(0, 0, 0, 0);
    rst_n = 1;

    send_word(32'hA5A50F0F, 0, 0);
    drain();
    chk("drop_after_1", drop_cnt, drops);
    chk("wr_data_hold", fifo_wr_data, 32'hA5A50F0F);

    send_word(32'h12345678, 0, 0);
    send_word(32'hDEADBEEF, 0, 0);
    drain();

    repeat (3) send_word($urandom, 1, 1);
    drain();
    chk("drop_3", drop_cnt, drops);
    repeat (5) send_word($urandom, 1, 1);
    drain();
    chk("drop_sat", drop_cnt, drops);
    send_word($urandom, 1, 0);
    drain();
    chk("drop_sat_hold", drop_cnt, drops);

    step(0, 0, 0, 0); rst_n = 0;
    step(0, 0, 0, 0); rst_n = 1; drops = 0;
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom % 2 == 1);
    drain();
    chk("drop_random", drop_cnt, drops);

    for (int i = 0; i < 20; i++) step(1, 0, 1, $urandom % 2 == 1);
    step(0, 0, 0, 0);
    send_word(32'h0F0F0F0F, 0, 0);
    drain();

    preload(32'hCAFEF00D);
    n0 = rd_cnt;
    do_read(c0, vc, bz);
    chk("rd_en_lat", rd_cyc - c0, 1);
    chk("valid_lat", vc - c0, 3);
    chk("busy_profile", bz[4:0], 5'b01110);
    chk("rd_count_1", rd_cnt - n0, 1);
    repeat (3) step(0, 0, 0, 0);
    chk("rd_data_hold", host_rd_data, 32'hCAFEF00D);

    step(0, 0, 0, 0);
    host_rd_req = 1; n0 = rd_cnt;
    repeat (10) step(0, 0, 0, 0);
    chk("no_rd_when_empty", rd_cnt - n0, 0);
    chk("busy_when_empty", busy, 0);
    push_valid = 1; push_w = 32'h600DCAFE; pc = cyc; vc = -1;
    for (int k = 0; k < 20 && vc < 0; k++) begin
      step(0, 0, 0, 0);
      @(negedge clk);
      if (host_rd_valid) vc = cyc;
    end
    chk("empty_release_lat", vc - pc, 4);
    step(0, 0, 0, 0);
    host_rd_req = 0;

    for (int i = 0; i < 3; i++) preload($urandom);
    n0 = rd_cnt; nv = 0;
    vq.delete();
    step(0, 0, 0, 0);
    host_rd_req = 1;
    for (int k = 0; k < 60 && nv < 3; k++) begin
      @(negedge clk);
      if (host_rd_valid) nv++;
    end
    step(0, 0, 0, 0);
    host_rd_req = 0;
    repeat (4) step(0, 0, 0, 0);
    chk("b2b_count", vq.size(), 3);
    chk("b2b_pops", rd_cnt - n0, 3);
    if (vq.size() == 3) begin
      chk("b2b_gap1", vq[1] - vq[0], 4);
      chk("b2b_gap2", vq[2] - vq[1], 4);
    end

    preload(32'h13579BDF);
    step(0, 0, 0, 0);
    host_rd_req = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 0; host_rd_req = 0;
    @(negedge clk);
    chk("busy_in_wait", busy, 1);
    step(0, 0, 0, 0);
    rst_n = 1; rq.delete(); drops = 0;
    @(negedge clk);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_valid", host_rd_valid, 0);
    chk("rst_wait_data", host_rd_data, 0);
    chk("rst_wait_drop", drop_cnt, drops);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      @(negedge clk);
      chk("rst_wait_no_valid", host_rd_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
